keypad_scanner: RTL

Scans a 4x4 matrix keypad and turns debounced key presses into hex nibbles. Each new nibble shifts into a 16-bit digit register sized for the four-digit multiplexed seven-segment driver. This block is the input side of the front panel: `dataout` connects directly to the display's `datain`, so typed digits scroll in from the right. Column drive mirrors the display ground drive: one-hot active-low, rotating.

---
 rtl/keypad_scanner.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad, debounces presses and releases on a
//   slow scan tick, and shifts each confirmed key code into a 16-bit digit
//   history that feeds the four-digit seven-segment display.
//
//   Parameters
//     SCAN_DIV        clk cycles per scan tick (2..65536)
//     DEBOUNCE_TICKS  consecutive stable ticks for press and release (1..15)
//   Ports
//     clk        system clock, rising edge
//     rst        asynchronous active-high reset
//     rows[3:0]  keypad rows, active-low, asynchronous to clk
//     cols[3:0]  column drive, one-hot active-low, rotating
//     key_valid  one-clk pulse on a confirmed press
//     key_code   code of the last confirmed key
//     dataout    digit history, newest nibble in [3:0]
module keypad_scanner #(
  parameter int SCAN_DIV       = 65536,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] dataout
);

  localparam int              DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DB_N     = 4'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  function automatic logic [3:0] rotate(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

  function automatic logic [1:0] col_idx(input logic [3:0] c);
    case (c)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Lowest-numbered low row wins when several rows are pulled low together.
  function automatic logic [1:0] low_row(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b00_00: return 4'h1;
      4'b00_01: return 4'h2;
      4'b00_10: return 4'h3;
      4'b00_11: return 4'hA;
      4'b01_00: return 4'h4;
      4'b01_01: return 4'h5;
      4'b01_10: return 4'h6;
      4'b01_11: return 4'hB;
      4'b10_00: return 4'h7;
      4'b10_01: return 4'h8;
      4'b10_10: return 4'h9;
      4'b10_11: return 4'hC;
      4'b11_00: return 4'hE;
      4'b11_01: return 4'h0;
      4'b11_10: return 4'hF;
      default:  return 4'hD;
    endcase
  endfunction

  logic [3:0]       rows_p0, rs;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  state_t           state, state_n;
  logic [3:0]       cols_n, pat, pat_n, dbc, dbc_n, rel, rel_n, code_n;
  logic [1:0]       kr, kr_n, kc, kc_n;
  logic             confirm;

  // Stage p0/p1: two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_p0 <= 4'hF;
      rs      <= 4'hF;
    end else begin
      rows_p0 <= rows;
      rs      <= rows_p0;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt <= '0;
    else     div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  always_comb begin
    state_n = state;
    cols_n  = cols;
    pat_n   = pat;
    kr_n    = kr;
    kc_n    = kc;
    dbc_n   = dbc;
    rel_n   = rel;
    confirm = 1'b0;
    code_n  = key_map(kr, kc);
    if (tick) begin
      case (state)
        SCAN: begin
          if (rs == 4'hF) begin
            cols_n = rotate(cols);
          end else begin
            pat_n = rs;
            kr_n  = low_row(rs);
            kc_n  = col_idx(cols);
            if (DEBOUNCE_TICKS == 1) begin
              confirm = 1'b1;
              code_n  = key_map(low_row(rs), col_idx(cols));
              rel_n   = 4'd0;
              state_n = HELD;
            end else begin
              dbc_n   = 4'd1;
              state_n = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (rs == pat) begin
            dbc_n = dbc + 4'd1;
            if (dbc + 4'd1 == DB_N) begin
              confirm = 1'b1;
              rel_n   = 4'd0;
              state_n = HELD;
            end
          end else begin
            cols_n  = rotate(cols);
            state_n = SCAN;
          end
        end
        HELD: begin
          if (rs == 4'hF) begin
            rel_n = rel + 4'd1;
            if (rel + 4'd1 == DB_N) begin
              cols_n  = rotate(cols);
              state_n = SCAN;
            end
          end else begin
            rel_n = 4'd0;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

  // Stage p2: scan state, columns and registered key outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      cols      <= 4'b1110;
      pat       <= 4'hF;
      kr        <= 2'd0;
      kc        <= 2'd0;
      dbc       <= 4'd0;
      rel       <= 4'd0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      dataout   <= 16'h0000;
    end else begin
      state     <= state_n;
      cols      <= cols_n;
      pat       <= pat_n;
      kr        <= kr_n;
      kc        <= kc_n;
      dbc       <= dbc_n;
      rel       <= rel_n;
      key_valid <= confirm;
      if (confirm) begin
        key_code <= code_n;
        dataout  <= {dataout[11:0], code_n};
      end
    end
  end

endmodule
